hex_word_rotator: RTL and testbench

- Upstream of the per-digit 2-bit-to-seven-segment character decoder.
- Generates one 2-bit character code per HEX display and rotates the word "dE1" across NUM_DIGITS displays at a fixed tick rate.
- The run/direction/single-step controls come from board switches and keys.
- Each CODES slice feeds one decoder instance directly.
- Character codes: 00=d, 01=E, 10=1, 11=blank.

---
 rtl/hex_word_pkg.sv | 25 ++
 rtl/tick_prescaler.sv | 30 +++
 rtl/hex_word_rotator.sv | 145 ++++++++++++++
 tb/tb_hex_word_rotator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_word_pkg.sv
// Character codes, FSM state type and message-slot lookup shared by the
// "dE1" word rotator and its testbench-facing helpers.
package hex_word_pkg;

  localparam logic [1:0] CHAR_D     = 2'b00;
  localparam logic [1:0] CHAR_E     = 2'b01;
  localparam logic [1:0] CHAR_ONE   = 2'b10;
  localparam logic [1:0] CHAR_BLANK = 2'b11;

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } rotor_state_t;

  // Slot k of the rotating message: "dE1" followed by blanks.
  function automatic logic [1:0] msg_slot(input int k);
    case (k)
      0:       return CHAR_D;
      1:       return CHAR_E;
      2:       return CHAR_ONE;
      default: return CHAR_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Rotation-tick prescaler: counts 0..TICK_DIV-1 while enabled; tick is the
// terminal-count strobe (combinational, qualified by en) so the caller can act on it.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic CLOCK_50,
  input  logic RESETN,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == CNT_LAST);

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hex_word_rotator.sv
// Rotates "dE1" across NUM_DIGITS character codes on prescaler ticks or key steps.
// Optional HEX_WORD_ROTATOR_GAP_EN: blank all digits for one interval after POS returns to 0.
//
// state   | meaning
// PAUSED  | prescaler held clear; synchronized key presses step POS
// RUNNING | prescaler counts; POS advances on each terminal count
module hex_word_rotator #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000000
) (
  input  logic                          CLOCK_50,
  input  logic                          RESETN,
  input  logic                          RUN,
  input  logic                          DIR,
  input  logic                          STEP_N,
  output logic [2*NUM_DIGITS-1:0]       CODES,
  output logic [$clog2(NUM_DIGITS)-1:0] POS,
  output logic                          TICK
);
  import hex_word_pkg::*;

  localparam int PW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] POS_LAST = PW'(NUM_DIGITS - 1);

  function automatic logic [2*NUM_DIGITS-1:0] build_codes(input logic [PW-1:0] pos);
    logic [2*NUM_DIGITS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      v[2*i +: 2] = msg_slot((NUM_DIGITS - 1 - i + int'(pos)) % NUM_DIGITS);
    return v;
  endfunction

  rotor_state_t            r_state, w_state_next;
  logic                    w_cnt_en, w_step_ok;
  logic                    r_step_s1, r_step_s2, r_step_s3;
  logic                    w_step, w_tc, w_adv;
  logic [PW-1:0]           r_pos, w_pos_next, w_pos_stepped;
  logic [2*NUM_DIGITS-1:0] r_codes, w_codes_next;
  logic                    r_tick;
`ifdef HEX_WORD_ROTATOR_GAP_EN
  logic                    r_gap, w_gap_next;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) r_state <= PAUSED;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_en     = 1'b0;
    w_step_ok    = 1'b0;
    case (r_state)
      PAUSED: begin
        w_step_ok = 1'b1;
        if (RUN) w_state_next = RUNNING;
      end
      RUNNING: begin
        w_cnt_en = 1'b1;
        if (!RUN) w_state_next = PAUSED;
      end
    endcase
  end

  // Two-flop synchronizer plus a third flop for falling-edge detection.
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      r_step_s1 <= 1'b1;
      r_step_s2 <= 1'b1;
      r_step_s3 <= 1'b1;
    end else begin
      r_step_s1 <= STEP_N;
      r_step_s2 <= r_step_s1;
      r_step_s3 <= r_step_s2;
    end
  end

  assign w_step = r_step_s3 & ~r_step_s2;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .CLOCK_50 (CLOCK_50),
    .RESETN   (RESETN),
    .en       (w_cnt_en),
    .clr      (~w_cnt_en),
    .tick     (w_tc)
  );

  assign w_adv = w_tc | (w_step & w_step_ok);

  always_comb begin
    if (DIR) w_pos_stepped = (r_pos == '0) ? POS_LAST : r_pos - 1'b1;
    else     w_pos_stepped = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
  end

  always_comb begin
    w_pos_next   = r_pos;
    w_codes_next = r_codes;
`ifdef HEX_WORD_ROTATOR_GAP_EN
    w_gap_next   = r_gap;
    if (w_adv) begin
      if (r_gap) begin
        // Leaving the gap restores the word without moving POS.
        w_gap_next   = 1'b0;
        w_codes_next = build_codes(r_pos);
      end else begin
        w_pos_next = w_pos_stepped;
        if (w_pos_stepped == '0) begin
          w_gap_next   = 1'b1;
          w_codes_next = '1;
        end else begin
          w_codes_next = build_codes(w_pos_stepped);
        end
      end
    end
`else
    if (w_adv) begin
      w_pos_next   = w_pos_stepped;
      w_codes_next = build_codes(w_pos_stepped);
    end
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      r_pos   <= '0;
      r_codes <= build_codes('0);
      r_tick  <= 1'b0;
`ifdef HEX_WORD_ROTATOR_GAP_EN
      r_gap   <= 1'b0;
`endif
    end else begin
      r_pos   <= w_pos_next;
      r_codes <= w_codes_next;
      r_tick  <= w_tc;
`ifdef HEX_WORD_ROTATOR_GAP_EN
      r_gap   <= w_gap_next;
`endif
    end
  end

  assign CODES = r_codes;
  assign POS   = r_pos;
  assign TICK  = r_tick;

endmodule

// File: tb/tb_hex_word_rotator.sv
// Scoreboard bench for hex_word_rotator (NUM_DIGITS=4, TICK_DIV=4): a cycle model
// pushes expected outputs, a negedge monitor pops and compares on every output event.
module tb_hex_word_rotator;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam logic [7:0] RESET_CODES = 8'b00_01_10_11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       dir = 1'b0;
  logic       step_n = 1'b1;
  logic [7:0] codes;
  logic [1:0] pos;
  logic       tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       tick;
    logic [1:0] pos;
    logic [7:0] codes;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  hex_word_rotator #(.NUM_DIGITS(N), .TICK_DIV(TD)) dut (
    .CLOCK_50 (clk),
    .RESETN   (rst_n),
    .RUN      (run),
    .DIR      (dir),
    .STEP_N   (step_n),
    .CODES    (codes),
    .POS      (pos),
    .TICK     (tick)
  );

  // HEXi shows message slot (N-1-i+pos) mod N; slots 0,1,2 are d,E,1 (codes 0,1,2), rest blank.
  function automatic logic [7:0] ref_codes(input int p);
    logic [7:0] v;
    int slot;
    v = '0;
    for (int i = 0; i < N; i++) begin
      slot = (p + N - 1 - i) % N;
      v[2*i +: 2] = (slot < 3) ? 2'(slot) : 2'b11;
    end
    return v;
  endfunction

  // Reference model: interval counter, running flag, position, raw key history.
  int   m_pos, m_cnt;
  bit   m_run, m_gap;
  bit   h0, h1, h2;
  bit   m_step, m_tick, m_adv;
  exp_t m_e;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pos = 0; m_cnt = 0; m_run = 0; m_gap = 0;
      h0 = 1; h1 = 1; h2 = 1;
      exp_q.delete();
    end else begin
      m_step = !h1 && h2;
      m_tick = m_run && (m_cnt == TD - 1);
      m_adv  = m_tick || (m_step && !m_run);
      m_cnt  = m_run ? (m_tick ? 0 : m_cnt + 1) : 0;
      m_run  = run;
      h2 = h1; h1 = h0; h0 = step_n;
      if (m_adv) begin
        m_e.tick = m_tick;
`ifdef HEX_WORD_ROTATOR_GAP_EN
        if (m_gap) begin
          m_gap = 0;
          m_e.codes = ref_codes(m_pos);
        end else begin
          m_pos = dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
          if (m_pos == 0) begin
            m_gap = 1;
            m_e.codes = 8'hFF;
          end else begin
            m_e.codes = ref_codes(m_pos);
          end
        end
`else
        m_pos = dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
        m_e.codes = ref_codes(m_pos);
`endif
        m_e.pos = 2'(m_pos);
        exp_q.push_back(m_e);
      end
    end
  end

  logic [1:0] prev_pos;
  logic [7:0] prev_codes;
  exp_t       got;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pos   = 2'd0;
      prev_codes = RESET_CODES;
    end else begin
      if (tick || pos != prev_pos || codes != prev_codes) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got tick=%0b pos=%0d codes=%b, none expected",
                   tick, pos, codes);
        end else begin
          got = exp_q.pop_front();
          if (tick !== got.tick || pos !== got.pos || codes !== got.codes) begin
            errors++;
            $display("FAIL scoreboard: got tick=%0b pos=%0d codes=%b expected tick=%0b pos=%0d codes=%b",
                     tick, pos, codes, got.tick, got.pos, got.codes);
          end
        end
        prev_pos   = pos;
        prev_codes = codes;
      end
      if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL missing_event: expected pos=%0d codes=%b, got pos=%0d codes=%b",
                 exp_q[0].pos, exp_q[0].codes, pos, codes);
        exp_q.delete();
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    chk("reset_codes", codes, RESET_CODES);
    chk("reset_pos", {6'd0, pos}, 8'd0);
    chk("reset_tick", {7'd0, tick}, 8'd0);
    rst_n = 1'b1;
  endtask

  task automatic press(input int n);
    step_n = 1'b0;
    cyc(n);
    step_n = 1'b1;
  endtask

  initial begin
    cyc(1);
    do_reset();
    // auto-rotate left, then right from reset
    run = 1'b1; dir = 1'b0;
    cyc(20);
    run = 1'b0;
    cyc(3);
    do_reset();
    run = 1'b1; dir = 1'b1;
    cyc(20);
    run = 1'b0;
    cyc(3);
    // paused stepping: short press and long hold, both directions
    for (int d = 0; d < 2; d++) begin
      dir = d[0];
      press(2); cyc(4);
      press(10); cyc(5);
    end
    // presses while running are discarded
    run = 1'b1;
    cyc(2); press(2); cyc(3); press(1); cyc(5);
    // pause mid-interval then resume
    run = 1'b0; cyc(3);
    run = 1'b1; cyc(12);
    // step pulse coinciding with the RUN 0->1 transition
    run = 1'b0; cyc(3);
    step_n = 1'b0; cyc(2);
    run = 1'b1; step_n = 1'b1;
    cyc(8);
    // randomized controls
    repeat (1500) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 29) == 0) dir = ~dir;
      if ($urandom_range(0, 5) == 0)  step_n = ~step_n;
      cyc(1);
    end
    step_n = 1'b1;
    // reset mid-interval, restart running straight out of reset
    run = 1'b1; dir = 1'b0;
    cyc(6);
    do_reset();
    cyc(12);
    run = 1'b0;
    cyc(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
